spad_rd_arbiter: RTL and testbench

- Shares one SPad scratchpad between NUM_REQ read requesters and one write source.
- Read requesters are served round-robin, one grant per cycle.
- Each grant is turned into the SPad read enable and address. The SPad read data is routed back one cycle later with a one-hot response valid.
- Write traffic passes straight through. Any read that would collide with a same-cycle write to the same address is deferred, so a read never returns stale data.

---
 rtl/spad_arb_pkg.sv | 17 +
 rtl/spad_rd_arbiter_rr_picker.sv | 44 ++++
 rtl/spad_rd_arbiter.sv | 95 +++++++++
 tb/tb_spad_rd_arbiter.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/spad_arb_pkg.sv
// Shared definitions for the SPad read arbiter: default widths, the
// requester vector type and the packed-address slice helper.
package spad_arb_pkg;

  localparam int unsigned DEF_NUM_REQ       = 4;
  localparam int unsigned DEF_DATA_BITWIDTH = 16;
  localparam int unsigned DEF_ADDR_BITWIDTH = 9;

  typedef logic [DEF_NUM_REQ-1:0] req_vec_t;

  // LSB position of requester k's address inside the packed address bus.
  function automatic int unsigned addr_slice(input int unsigned k,
                                             input int unsigned addr_bits);
    return k * addr_bits;
  endfunction

endpackage

// File: rtl/spad_rd_arbiter_rr_picker.sv
// Round-robin picker: given the eligible requesters and the current
// pointer, select the first eligible requester at or after the pointer
// (wrapping) and produce the one-hot grant and the following pointer.
module rr_picker #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned PTR_W   = 2
) (
  input  logic [NUM_REQ-1:0] elig,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [PTR_W-1:0]   next_ptr,
  output logic               hit
);

  int unsigned best_k;
  int unsigned best_dist;

  // Priority is the rotational distance from the pointer; smallest wins.
  always_comb begin
    best_k    = 0;
    best_dist = NUM_REQ;
    hit       = 1'b0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (elig[k] && (((k + NUM_REQ - 32'(ptr)) % NUM_REQ) < best_dist)) begin
        best_k    = k;
        best_dist = (k + NUM_REQ - 32'(ptr)) % NUM_REQ;
        hit       = 1'b1;
      end
    end
  end

  // One-hot grant and pointer advance past the winner.
  always_comb begin
    grant    = '0;
    next_ptr = ptr;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      grant[k] = hit && (k == best_k);
    end
    if (hit) begin
      next_ptr = PTR_W'((best_k + 1) % NUM_REQ);
    end
  end

endmodule

// File: rtl/spad_rd_arbiter.sv
// SPad read arbiter: shares one scratchpad between NUM_REQ read requesters
// (round-robin, one grant per cycle) and a pass-through write port. Reads
// colliding with a same-cycle write to the same address are held off one
// cycle so they return the freshly written word.
module spad_rd_arbiter
  import spad_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ       = DEF_NUM_REQ,
  parameter int unsigned DATA_BITWIDTH = DEF_DATA_BITWIDTH,
  parameter int unsigned ADDR_BITWIDTH = DEF_ADDR_BITWIDTH
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             i_en,
  input  logic [NUM_REQ-1:0]               i_req_valid,
  input  logic [NUM_REQ*ADDR_BITWIDTH-1:0] i_req_addr,
  output logic [NUM_REQ-1:0]               o_req_ready,
  output logic [NUM_REQ-1:0]               o_rsp_valid,
  output logic [DATA_BITWIDTH-1:0]         o_rsp_data,
  input  logic                             i_wr_valid,
  input  logic [ADDR_BITWIDTH-1:0]         i_wr_addr,
  input  logic [DATA_BITWIDTH-1:0]         i_wr_data,
  output logic                             o_spad_ren,
  output logic [ADDR_BITWIDTH-1:0]         o_spad_raddr,
  output logic                             o_spad_wen,
  output logic [ADDR_BITWIDTH-1:0]         o_spad_waddr,
  output logic [DATA_BITWIDTH-1:0]         o_spad_wdata,
  input  logic [DATA_BITWIDTH-1:0]         i_spad_rdata,
  output logic                             o_busy
);

  localparam int unsigned PTR_W = $clog2(NUM_REQ);

  logic [ADDR_BITWIDTH-1:0] req_addr [NUM_REQ];
  logic [NUM_REQ-1:0]       elig;
  logic [NUM_REQ-1:0]       grant;
  logic [NUM_REQ-1:0]       rsp_vld;
  logic [PTR_W-1:0]         rr_ptr;
  logic [PTR_W-1:0]         rr_ptr_nxt;
  logic                     grant_hit;

  // Unpack addresses and qualify requests; reset low suppresses all grants.
  always_comb begin
    elig = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      req_addr[k] = i_req_addr[addr_slice(k, ADDR_BITWIDTH) +: ADDR_BITWIDTH];
      elig[k]     = reset && i_en && i_req_valid[k]
                    && !(i_wr_valid && (req_addr[k] == i_wr_addr));
    end
  end

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_picker (
    .elig     (elig),
    .ptr      (rr_ptr),
    .grant    (grant),
    .next_ptr (rr_ptr_nxt),
    .hit      (grant_hit)
  );

  // Route the granted requester's address to the SPad read port.
  always_comb begin
    o_spad_raddr = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (grant[k]) begin
        o_spad_raddr = req_addr[k];
      end
    end
  end

  // Round-robin pointer and one-cycle response tag register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr  <= '0;
      rsp_vld <= '0;
    end else begin
      if (grant_hit) begin
        rr_ptr <= rr_ptr_nxt;
      end
      rsp_vld <= grant;
    end
  end

  assign o_req_ready  = grant;
  assign o_spad_ren   = grant_hit;
  assign o_rsp_valid  = rsp_vld;
  assign o_rsp_data   = (|rsp_vld) ? i_spad_rdata : '0;
  assign o_spad_wen   = reset && i_wr_valid;
  assign o_spad_waddr = i_wr_addr;
  assign o_spad_wdata = i_wr_data;
  assign o_busy       = reset && ((|i_req_valid) || (|rsp_vld));

endmodule

// File: tb/tb_spad_rd_arbiter.sv
// Directed testbench for spad_rd_arbiter with a registered-read SPad model.
module tb_spad_rd_arbiter;
  import spad_arb_pkg::*;

  localparam int unsigned NR = 4;
  localparam int unsigned DW = 16;
  localparam int unsigned AW = 9;

  logic            clk = 1'b0;
  logic            reset;
  logic            en;
  req_vec_t        req_valid;
  logic [NR*AW-1:0] req_addr;
  req_vec_t        req_ready;
  req_vec_t        rsp_valid;
  logic [DW-1:0]   rsp_data;
  logic            wr_valid;
  logic [AW-1:0]   wr_addr;
  logic [DW-1:0]   wr_data;
  logic            spad_ren;
  logic [AW-1:0]   spad_raddr;
  logic            spad_wen;
  logic [AW-1:0]   spad_waddr;
  logic [DW-1:0]   spad_wdata;
  logic [DW-1:0]   spad_rdata = '0;
  logic            busy;

  logic [DW-1:0]   mem [0:(1<<AW)-1];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  spad_rd_arbiter #(
    .NUM_REQ       (NR),
    .DATA_BITWIDTH (DW),
    .ADDR_BITWIDTH (AW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .i_en         (en),
    .i_req_valid  (req_valid),
    .i_req_addr   (req_addr),
    .o_req_ready  (req_ready),
    .o_rsp_valid  (rsp_valid),
    .o_rsp_data   (rsp_data),
    .i_wr_valid   (wr_valid),
    .i_wr_addr    (wr_addr),
    .i_wr_data    (wr_data),
    .o_spad_ren   (spad_ren),
    .o_spad_raddr (spad_raddr),
    .o_spad_wen   (spad_wen),
    .o_spad_waddr (spad_waddr),
    .o_spad_wdata (spad_wdata),
    .i_spad_rdata (spad_rdata),
    .o_busy       (busy)
  );

  // SPad model: synchronous write, registered read.
  always @(posedge clk) begin
    if (spad_wen) mem[spad_waddr] <= spad_wdata;
    if (spad_ren) spad_rdata <= mem[spad_raddr];
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int k, input logic [AW-1:0] a);
    req_addr[k*AW +: AW] = a;
    req_valid[k] = 1'b1;
  endtask

  initial begin
    logic [3:0] oh;
    for (int i = 0; i < (1<<AW); i++) mem[i] = 16'h0000;
    mem[9'h005] = 16'hBEEF;
    mem[9'h010] = 16'h0BAD;
    mem[9'h020] = 16'h2222;
    for (int k = 0; k < 4; k++) mem[9'h100 + k] = 16'hA000 + 16'(k);

    reset = 1'b0; en = 1'b1; req_valid = '0; req_addr = '0;
    wr_valid = 1'b0; wr_addr = '0; wr_data = '0;

    // Reset state with traffic present on the inputs
    for (int k = 0; k < 4; k++) set_req(k, 9'h100 + 9'(k));
    wr_valid = 1'b1; wr_addr = 9'h1FF; wr_data = 16'hFFFF;
    #2;
    check_eq("rst_ready", 32'(req_ready), 32'h0);
    check_eq("rst_ren",   32'(spad_ren),  32'h0);
    check_eq("rst_wen",   32'(spad_wen),  32'h0);
    check_eq("rst_busy",  32'(busy),      32'h0);
    tick();
    check_eq("rst_rsp",   32'(rsp_valid), 32'h0);
    req_valid = '0; wr_valid = 1'b0;
    reset = 1'b1;

    // Single read
    set_req(0, 9'h005);
    #1;
    check_eq("t1_ready", 32'(req_ready),  32'h1);
    check_eq("t1_ren",   32'(spad_ren),   32'h1);
    check_eq("t1_raddr", 32'(spad_raddr), 32'h005);
    tick();
    req_valid = '0;
    #1;
    check_eq("t1_rsp_v", 32'(rsp_valid), 32'h1);
    check_eq("t1_rsp_d", 32'(rsp_data),  32'hBEEF);
    check_eq("t1_busy",  32'(busy),      32'h1);

    // Return pointer to 0
    reset = 1'b0; tick(); tick(); reset = 1'b1;

    // All four requesters streaming for 8 cycles
    for (int k = 0; k < 4; k++) set_req(k, 9'h100 + 9'(k));
    for (int i = 0; i < 8; i++) begin
      #1;
      oh = 4'b0001 << (i % 4);
      check_eq($sformatf("t2_ready%0d", i), 32'(req_ready),  32'(oh));
      check_eq($sformatf("t2_raddr%0d", i), 32'(spad_raddr), 32'h100 + 32'(i % 4));
      if (i > 0) begin
        oh = 4'b0001 << ((i - 1) % 4);
        check_eq($sformatf("t2_rsp_v%0d", i), 32'(rsp_valid), 32'(oh));
        check_eq($sformatf("t2_rsp_d%0d", i), 32'(rsp_data),  32'hA000 + 32'((i - 1) % 4));
      end
      tick();
    end
    req_valid = '0;
    #1;
    check_eq("t2_rsp_v_last", 32'(rsp_valid), 32'h8);
    check_eq("t2_rsp_d_last", 32'(rsp_data),  32'hA003);
    tick();
    check_eq("t2_idle_rsp", 32'(rsp_valid), 32'h0);
    check_eq("t2_idle_data", 32'(rsp_data), 32'h0);

    // Hazard: write and read to the same address in the same cycle
    set_req(1, 9'h010);
    wr_valid = 1'b1; wr_addr = 9'h010; wr_data = 16'h1234;
    #1;
    check_eq("t3_hold_ready", 32'(req_ready),  32'h0);
    check_eq("t3_hold_ren",   32'(spad_ren),   32'h0);
    check_eq("t3_hold_raddr", 32'(spad_raddr), 32'h0);
    check_eq("t3_wen",        32'(spad_wen),   32'h1);
    check_eq("t3_waddr",      32'(spad_waddr), 32'h010);
    check_eq("t3_wdata",      32'(spad_wdata), 32'h1234);
    check_eq("t3_busy",       32'(busy),       32'h1);
    tick();
    wr_valid = 1'b0;
    #1;
    check_eq("t3_ready", 32'(req_ready),  32'h2);
    check_eq("t3_raddr", 32'(spad_raddr), 32'h010);
    tick();
    req_valid = '0;
    #1;
    check_eq("t3_rsp_v", 32'(rsp_valid), 32'h2);
    check_eq("t3_rsp_d", 32'(rsp_data),  32'h1234);

    // Hazard with bystander: req2 served in the hold cycle, req1 right after
    set_req(1, 9'h010);
    set_req(2, 9'h020);
    wr_valid = 1'b1; wr_addr = 9'h010; wr_data = 16'h5678;
    #1;
    check_eq("t4_ready_a", 32'(req_ready),  32'h4);
    check_eq("t4_raddr_a", 32'(spad_raddr), 32'h020);
    tick();
    wr_valid = 1'b0; req_valid[2] = 1'b0;
    #1;
    check_eq("t4_rsp_v_a", 32'(rsp_valid),  32'h4);
    check_eq("t4_rsp_d_a", 32'(rsp_data),   32'h2222);
    check_eq("t4_ready_b", 32'(req_ready),  32'h2);
    check_eq("t4_raddr_b", 32'(spad_raddr), 32'h010);
    tick();
    req_valid = '0;
    #1;
    check_eq("t4_rsp_v_b", 32'(rsp_valid), 32'h2);
    check_eq("t4_rsp_d_b", 32'(rsp_data),  32'h5678);

    // Enable low with requests pending; pointer is 2
    en = 1'b0;
    set_req(0, 9'h100);
    set_req(3, 9'h103);
    tick();
    check_eq("t5_off_ready", 32'(req_ready), 32'h0);
    check_eq("t5_off_ren",   32'(spad_ren),  32'h0);
    check_eq("t5_off_busy",  32'(busy),      32'h1);
    tick();
    check_eq("t5_off_rsp",   32'(rsp_valid), 32'h0);
    en = 1'b1;
    #1;
    check_eq("t5_ready_a", 32'(req_ready),  32'h8);
    check_eq("t5_raddr_a", 32'(spad_raddr), 32'h103);
    tick();
    req_valid[3] = 1'b0;
    #1;
    check_eq("t5_rsp_v_a", 32'(rsp_valid), 32'h8);
    check_eq("t5_rsp_d_a", 32'(rsp_data),  32'hA003);
    check_eq("t5_ready_b", 32'(req_ready), 32'h1);
    tick();
    en = 1'b0; req_valid = '0;
    #1;
    check_eq("t5_rsp_v_b", 32'(rsp_valid), 32'h1);
    check_eq("t5_rsp_d_b", 32'(rsp_data),  32'hA000);
    en = 1'b1;
    tick();

    // Reset lands before the response edge; pointer is 1
    set_req(1, 9'h101);
    #1;
    check_eq("t6_ready", 32'(req_ready), 32'h2);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_eq("t6_rst_ready", 32'(req_ready), 32'h0);
    check_eq("t6_rst_rsp0",  32'(rsp_valid), 32'h0);
    tick();
    check_eq("t6_rst_rsp1",  32'(rsp_valid), 32'h0);
    check_eq("t6_rst_data",  32'(rsp_data),  32'h0);
    tick();
    check_eq("t6_rst_rsp2",  32'(rsp_valid), 32'h0);
    set_req(0, 9'h100);
    reset = 1'b1;
    #1;
    check_eq("t6_post_ready", 32'(req_ready),  32'h1);
    check_eq("t6_post_raddr", 32'(spad_raddr), 32'h100);
    tick();
    req_valid = '0;
    #1;
    check_eq("t6_post_rsp_v", 32'(rsp_valid), 32'h1);
    check_eq("t6_post_rsp_d", 32'(rsp_data),  32'hA000);
    tick();
    check_eq("t6_idle_busy", 32'(busy), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
